// File: rtl/cmd_arbiter.sv
// Command arbiter: picks one of three requesters (manual, semi-auto, auto)
// according to the driving mode, holds the winner's command byte on the UART
// transmit path for HOLD_CYCLES, then sends idle bytes for GAP_CYCLES.
// At normal hold completion the winner is acked and the detector bits of the
// received byte are snapshotted.
module cmd_arbiter #(
  parameter int unsigned HOLD_CYCLES = 1000000,
  parameter int unsigned GAP_CYCLES  = 100000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       power,
  input  logic [1:0] mode_sel,
  input  logic       man_req,
  input  logic       semi_req,
  input  logic       auto_req,
  input  logic [5:0] man_cmd,
  input  logic [5:0] semi_cmd,
  input  logic [5:0] auto_cmd,
  input  logic [7:0] rec,
  output logic [7:0] cmd_byte,
  output logic       man_ack,
  output logic       semi_ack,
  output logic       auto_ack,
  output logic       abort,
  output logic       busy,
  output logic [1:0] grant_id,
  output logic [3:0] det_q,
  output logic       det_valid
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_IDLE = 2'b01,
    ST_HOLD = 2'b10,
    ST_GAP  = 2'b11
  } state_t;

  localparam logic [7:0]  IDLE_BYTE = 8'b1000_0000;
  localparam logic [19:0] HOLD_LOAD = 20'(HOLD_CYCLES - 32'd1);
  localparam logic [19:0] GAP_LOAD  = 20'(GAP_CYCLES - 32'd1);

  localparam logic [1:0] ID_NONE = 2'b00;
  localparam logic [1:0] ID_MAN  = 2'b01;
  localparam logic [1:0] ID_SEMI = 2'b10;
  localparam logic [1:0] ID_AUTO = 2'b11;

  // Whether requester `id` may hold the line in driving mode `mode`.
  // Mode 11 falls through like manual: only the manual requester qualifies.
  function automatic logic is_eligible(input logic [1:0] mode, input logic [1:0] id);
    logic ok;
    ok = 1'b0;
    case (id)
      ID_MAN:  ok = 1'b1;
      ID_SEMI: ok = (mode == 2'b01) || (mode == 2'b10);
      ID_AUTO: ok = (mode == 2'b10);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [5:0]  cmd_q, cmd_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic [1:0]  grant_q, grant_d;
  logic        busy_q, busy_d;
  logic        man_ack_q, man_ack_d;
  logic        semi_ack_q, semi_ack_d;
  logic        auto_ack_q, auto_ack_d;
  logic        abort_q, abort_d;
  logic [3:0]  det_snap_q, det_snap_d;
  logic        det_valid_q, det_valid_d;

  logic [1:0]  win_id;
  logic [5:0]  win_cmd;

  // Only the four detector bits of the received byte are used.
  logic        unused_rec_hi;
  assign unused_rec_hi = ^rec[7:4];

  // Fixed-priority pick among requests that are eligible in the current mode.
  always_comb begin
    win_id  = ID_NONE;
    win_cmd = 6'd0;
    if (man_req) begin
      win_id  = ID_MAN;
      win_cmd = man_cmd;
    end else if (semi_req && is_eligible(mode_sel, ID_SEMI)) begin
      win_id  = ID_SEMI;
      win_cmd = semi_cmd;
    end else if (auto_req && is_eligible(mode_sel, ID_AUTO)) begin
      win_id  = ID_AUTO;
      win_cmd = auto_cmd;
    end else begin
      win_id  = ID_NONE;
      win_cmd = 6'd0;
    end
  end

  // Next-state, counter, capture and output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    grant_d     = grant_q;
    man_ack_d   = 1'b0;
    semi_ack_d  = 1'b0;
    auto_ack_d  = 1'b0;
    abort_d     = 1'b0;
    det_snap_d  = det_snap_q;
    det_valid_d = 1'b0;

    case (state_q)
      ST_OFF: begin
        cnt_d   = 20'd0;
        grant_d = ID_NONE;
        if (power) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OFF;
        end
      end

      ST_IDLE: begin
        if (win_id != ID_NONE) begin
          state_d = ST_HOLD;
          grant_d = win_id;
          cmd_d   = win_cmd;
          cnt_d   = HOLD_LOAD;
        end else begin
          state_d = ST_IDLE;
          grant_d = ID_NONE;
        end
      end

      ST_HOLD: begin
        // A mode change that disqualifies the holder cuts the hold short,
        // even on what would have been its final cycle.
        if (!is_eligible(mode_sel, grant_q)) begin
          state_d = ST_GAP;
          abort_d = 1'b1;
          grant_d = ID_NONE;
          cnt_d   = GAP_LOAD;
        end else if (cnt_q == 20'd0) begin
          state_d     = ST_GAP;
          grant_d     = ID_NONE;
          cnt_d       = GAP_LOAD;
          det_snap_d  = rec[3:0];
          det_valid_d = 1'b1;
          case (grant_q)
            ID_MAN:  man_ack_d  = 1'b1;
            ID_SEMI: semi_ack_d = 1'b1;
            ID_AUTO: auto_ack_d = 1'b1;
            default: man_ack_d  = 1'b0;
          endcase
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end

      ST_GAP: begin
        grant_d = ID_NONE;
        if (cnt_q == 20'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end

      default: begin
        state_d = ST_OFF;
        cnt_d   = 20'd0;
        grant_d = ID_NONE;
      end
    endcase

    // Loss of power overrides everything, including a completing hold.
    if (!power) begin
      state_d     = ST_OFF;
      cnt_d       = 20'd0;
      cmd_d       = 6'd0;
      grant_d     = ID_NONE;
      man_ack_d   = 1'b0;
      semi_ack_d  = 1'b0;
      auto_ack_d  = 1'b0;
      abort_d     = 1'b0;
      det_snap_d  = det_snap_q;
      det_valid_d = 1'b0;
    end else begin
      state_d = state_d;
    end

    // Outputs are registered alongside the state they describe.
    if (state_d == ST_HOLD) begin
      cmd_byte_d = {2'b10, cmd_d};
    end else begin
      cmd_byte_d = IDLE_BYTE;
    end
    busy_d = (state_d == ST_HOLD) || (state_d == ST_GAP);
  end

  // State machine and output registers with asynchronous active-low reset.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_OFF;
      cnt_q       <= 20'd0;
      cmd_q       <= 6'd0;
      cmd_byte_q  <= IDLE_BYTE;
      grant_q     <= ID_NONE;
      busy_q      <= 1'b0;
      man_ack_q   <= 1'b0;
      semi_ack_q  <= 1'b0;
      auto_ack_q  <= 1'b0;
      abort_q     <= 1'b0;
      det_snap_q  <= 4'd0;
      det_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      cmd_byte_q  <= cmd_byte_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      man_ack_q   <= man_ack_d;
      semi_ack_q  <= semi_ack_d;
      auto_ack_q  <= auto_ack_d;
      abort_q     <= abort_d;
      det_snap_q  <= det_snap_d;
      det_valid_q <= det_valid_d;
    end
  end

  assign cmd_byte  = cmd_byte_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;
  assign man_ack   = man_ack_q;
  assign semi_ack  = semi_ack_q;
  assign auto_ack  = auto_ack_q;
  assign abort     = abort_q;
  assign det_q     = det_snap_q;
  assign det_valid = det_valid_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed bench for cmd_arbiter with a short hold (4) and gap (2).
module tb_cmd_arbiter;

  logic       sys_clk;
  logic       rst;
  logic       power;
  logic [1:0] mode_sel;
  logic       man_req, semi_req, auto_req;
  logic [5:0] man_cmd, semi_cmd, auto_cmd;
  logic [7:0] rec;
  logic [7:0] cmd_byte;
  logic       man_ack, semi_ack, auto_ack, abort, busy, det_valid;
  logic [1:0] grant_id;
  logic [3:0] det_q;

  int n_cmp = 0;
  int n_err = 0;

  cmd_arbiter #(.HOLD_CYCLES(4), .GAP_CYCLES(2)) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .power    (power),
    .mode_sel (mode_sel),
    .man_req  (man_req),
    .semi_req (semi_req),
    .auto_req (auto_req),
    .man_cmd  (man_cmd),
    .semi_cmd (semi_cmd),
    .auto_cmd (auto_cmd),
    .rec      (rec),
    .cmd_byte (cmd_byte),
    .man_ack  (man_ack),
    .semi_ack (semi_ack),
    .auto_ack (auto_ack),
    .abort    (abort),
    .busy     (busy),
    .grant_id (grant_id),
    .det_q    (det_q),
    .det_valid(det_valid)
  );

  // 100 MHz clock.
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One rising edge, then settle at the following falling edge.
  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  initial begin
    rst = 1'b0; power = 1'b0; mode_sel = 2'b00;
    man_req = 1'b0; semi_req = 1'b0; auto_req = 1'b0;
    man_cmd = 6'd0; semi_cmd = 6'd0; auto_cmd = 6'd0; rec = 8'h00;

    // Reset values.
    @(negedge sys_clk);
    check_eq("rst_byte", 32'(cmd_byte), 32'h80);
    check_eq("rst_grant", 32'(grant_id), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_det", 32'(det_q), 32'd0);

    // Basic manual transaction with capture stability and detector snapshot.
    rst = 1'b1; power = 1'b1; mode_sel = 2'b00;
    man_req = 1'b1; man_cmd = 6'b000001; rec = 8'h05;
    tick();
    check_eq("off_to_idle_byte", 32'(cmd_byte), 32'h80);
    check_eq("off_to_idle_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("hold_byte", 32'(cmd_byte), 32'h81);
      check_eq("hold_no_ack", 32'(man_ack), 32'd0);
      if (i == 0) begin
        check_eq("hold_grant_man", 32'(grant_id), 32'd1);
        man_req = 1'b0;
        man_cmd = 6'h3F;
      end
    end
    tick();
    check_eq("gap1_byte", 32'(cmd_byte), 32'h80);
    check_eq("gap1_man_ack", 32'(man_ack), 32'd1);
    check_eq("gap1_det_valid", 32'(det_valid), 32'd1);
    check_eq("gap1_det_q", 32'(det_q), 32'd5);
    check_eq("gap1_grant", 32'(grant_id), 32'd0);
    check_eq("gap1_busy", 32'(busy), 32'd1);
    check_eq("gap1_abort", 32'(abort), 32'd0);
    tick();
    check_eq("gap2_ack_once", 32'(man_ack), 32'd0);
    check_eq("gap2_det_valid", 32'(det_valid), 32'd0);
    check_eq("gap2_busy", 32'(busy), 32'd1);
    check_eq("gap2_byte", 32'(cmd_byte), 32'h80);
    tick();
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Auto mode, all requesting: manual wins, is re-granted, then semi.
    mode_sel = 2'b10; man_req = 1'b1; semi_req = 1'b1; auto_req = 1'b1;
    man_cmd = 6'b000001; semi_cmd = 6'b000010; auto_cmd = 6'b000100;
    tick();
    check_eq("prio_grant_man", 32'(grant_id), 32'd1);
    repeat (3) tick();
    tick();
    check_eq("prio_man_ack", 32'(man_ack), 32'd1);
    check_eq("prio_semi_ack", 32'(semi_ack), 32'd0);
    check_eq("prio_auto_ack", 32'(auto_ack), 32'd0);
    tick();
    tick();
    check_eq("b2b_idle_grant", 32'(grant_id), 32'd0);
    tick();
    check_eq("b2b_regrant_man", 32'(grant_id), 32'd1);
    man_req = 1'b0;
    repeat (6) tick();
    tick();
    check_eq("next_grant_semi", 32'(grant_id), 32'd2);
    check_eq("semi_byte", 32'(cmd_byte), 32'h82);

    // Ineligible requests produce no grant.
    semi_req = 1'b0; auto_req = 1'b0;
    repeat (6) tick();
    check_eq("back_idle_busy", 32'(busy), 32'd0);
    mode_sel = 2'b01; auto_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("semi_mode_auto_grant", 32'(grant_id), 32'd0);
      check_eq("semi_mode_auto_byte", 32'(cmd_byte), 32'h80);
      check_eq("semi_mode_auto_busy", 32'(busy), 32'd0);
    end
    auto_req = 1'b0; mode_sel = 2'b11; semi_req = 1'b1;
    tick();
    check_eq("mode11_semi_grant", 32'(grant_id), 32'd0);
    semi_req = 1'b0;

    // Mode change during a semi hold aborts it.
    mode_sel = 2'b01; semi_req = 1'b1; semi_cmd = 6'b000010;
    tick();
    check_eq("abort_grant_semi", 32'(grant_id), 32'd2);
    semi_req = 1'b0;
    tick();
    check_eq("abort_hold2_byte", 32'(cmd_byte), 32'h82);
    mode_sel = 2'b00;
    tick();
    check_eq("abort_pulse", 32'(abort), 32'd1);
    check_eq("abort_byte", 32'(cmd_byte), 32'h80);
    check_eq("abort_no_ack", 32'(semi_ack), 32'd0);
    check_eq("abort_no_det_valid", 32'(det_valid), 32'd0);
    check_eq("abort_grant", 32'(grant_id), 32'd0);
    tick();
    check_eq("abort_once", 32'(abort), 32'd0);
    check_eq("abort_gap2_ack", 32'(semi_ack), 32'd0);
    check_eq("abort_gap2_busy", 32'(busy), 32'd1);
    tick();
    check_eq("abort_idle_busy", 32'(busy), 32'd0);

    // Power loss mid-hold.
    man_req = 1'b1; man_cmd = 6'h10;
    tick();
    check_eq("pwr_hold_byte", 32'(cmd_byte), 32'h90);
    man_req = 1'b0;
    tick();
    power = 1'b0;
    tick();
    check_eq("pwr_off_byte", 32'(cmd_byte), 32'h80);
    check_eq("pwr_off_grant", 32'(grant_id), 32'd0);
    check_eq("pwr_off_busy", 32'(busy), 32'd0);
    check_eq("pwr_off_ack", 32'(man_ack), 32'd0);
    check_eq("pwr_off_abort", 32'(abort), 32'd0);
    power = 1'b1;
    tick();
    check_eq("pwr_on_ack", 32'(man_ack), 32'd0);

    // Power loss on the completing edge: power wins.
    man_req = 1'b1; man_cmd = 6'b000010;
    tick();
    check_eq("pwr_end_hold_byte", 32'(cmd_byte), 32'h82);
    man_req = 1'b0;
    repeat (3) tick();
    power = 1'b0;
    tick();
    check_eq("pwr_end_ack", 32'(man_ack), 32'd0);
    check_eq("pwr_end_busy", 32'(busy), 32'd0);
    check_eq("pwr_end_det_valid", 32'(det_valid), 32'd0);
    power = 1'b1;
    tick();

    // Asynchronous reset mid-hold.
    man_req = 1'b1; man_cmd = 6'b000001;
    tick();
    check_eq("arst_pre_busy", 32'(busy), 32'd1);
    man_req = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_eq("arst_byte", 32'(cmd_byte), 32'h80);
    check_eq("arst_grant", 32'(grant_id), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_det", 32'(det_q), 32'd0);
    @(negedge sys_clk);
    check_eq("arst_held_byte", 32'(cmd_byte), 32'h80);
    rst = 1'b1;
    tick();
    check_eq("arst_rel_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("arst_no_ack", 32'(man_ack), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cmd_arbiter.md
CMD_ARBITER -- requirements
Module: cmd_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 1000000, SHALL set the number of cycles a granted command byte is held on cmd_byte (10 ms at 100 MHz); legal range 1 to 2^20-1.
REQ-002 Parameter GAP_CYCLES, default 100000, SHALL set the number of idle-byte cycles inserted after every hold; legal range 1 to 2^20-1.
REQ-003 sys_clk  in  1  sole clock, 100 MHz, rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 power  in  1  engine power status (1 = on).
REQ-006 mode_sel  in  2  driving mode: 00 manual, 01 semi-auto, 10 auto, 11 treated as manual.
REQ-007 man_req, semi_req, auto_req  in  1 each  level request from the manual, semi-auto and auto requesters.
REQ-008 man_cmd, semi_cmd, auto_cmd  in  6 each  command bits {destroy, place, right, left, back, forward}.
REQ-009 rec  in  8  byte received from the UART; bits [3:0] = {back, right, left, front} detectors.
REQ-010 cmd_byte  out  8  byte driven to the UART transmitter.
REQ-011 man_ack, semi_ack, auto_ack  out  1 each  one-cycle completion pulse.
REQ-012 abort  out  1  one-cycle pulse when a hold is cut short.
REQ-013 busy  out  1  high in HOLD or GAP.
REQ-014 grant_id  out  2  00 none, 01 manual, 10 semi, 11 auto.
REQ-015 det_q  out  4  detector snapshot; det_valid  out  1  one-cycle pulse when det_q updates.

Function
REQ-016 FSM states: OFF, IDLE, HOLD, GAP; one 20-bit down-counter shared by HOLD and GAP.
REQ-017 Idle byte SHALL be 8'b1000_0000; in HOLD cmd_byte SHALL be {2'b10, captured 6-bit cmd}; in all other states, idle byte.
REQ-018 Eligibility: manual mode -> man only; semi -> man, semi; auto -> man, semi, auto.
REQ-019 Fixed priority among eligible requests: man > semi > auto.
REQ-020 OFF -> IDLE on the first edge with power=1; any state -> OFF on any edge with power=0, no ack, no abort.
REQ-021 IDLE with an eligible request at edge N: state = HOLD, grant_id set and winner's cmd captured at edge N; cmd_byte shows it from cycle N+1.
REQ-022 HOLD SHALL last exactly HOLD_CYCLES cycles; the captured cmd SHALL NOT change if the requester's cmd or req changes.
REQ-023 HOLD -> GAP at normal completion: winner's ack pulses in the first GAP cycle; det_q <= rec[3:0] and det_valid pulses in that same cycle.
REQ-024 If mode_sel changes so the granted requester becomes ineligible during HOLD: next edge -> GAP, abort pulses one cycle, no ack, no det_valid.
REQ-025 GAP SHALL last exactly GAP_CYCLES cycles, then -> IDLE; requests are ignored during GAP.
REQ-026 grant_id SHALL be 00 outside HOLD.
REQ-027 Request held high across GAP SHALL be re-granted on the first IDLE edge (back-to-back transactions).
REQ-028 Simultaneous power=0 and HOLD completion: power wins; state -> OFF, no ack.
REQ-029 At most one ack or abort SHALL be asserted in any cycle.

Reset
REQ-030 rst=0 SHALL immediately force state OFF, counter 0, cmd_byte 8'b1000_0000, grant_id 00, det_q 0000, and all pulses, busy and captured cmd to 0.
REQ-031 After rst release the block SHALL follow REQ-020; reset mid-HOLD SHALL produce no ack.

Verification (HOLD_CYCLES=4, GAP_CYCLES=2)
REQ-032 power=1, mode 00, man_req=1 and man_cmd=000001 -> cmd_byte 8'h81 for 4 cycles; man_ack then pulses once; 2 cycles of 8'h80.
REQ-033 mode 10, all three requests high -> grant_id 01 (manual), then 01 again after GAP while man_req stays high; drop man_req -> semi granted next.
REQ-034 mode 01, only auto_req=1 -> no grant, cmd_byte stays 8'h80, busy=0.
REQ-035 Semi granted in mode 01, mode_sel -> 00 in hold cycle 2 -> abort pulse, 8'h80, no semi_ack, then IDLE after 2 cycles.
REQ-036 rec=8'h05 at HOLD end -> det_q=0101, det_valid one cycle; power=0 mid-HOLD -> OFF, 8'h80, no ack.
REQ-037 rst low mid-HOLD -> all outputs at reset values in the same cycle, asynchronously.
